// File: rtl/trans_scheduler.sv
// Burst command sequencer for the memory checker: latches test settings on start and
// issues read/write commands over valid/ready. Option: TRANS_SCHED_RND_ADDR_EN adds the LFSR address mode.
module trans_scheduler #(
   parameter int ADDR_W      = 6,
   parameter int AMM_BURST_W = 11,
   parameter int CNT_W       = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic [1:0]             test_mode_i,
   input  logic [2:0]             addr_mode_i,
   input  logic [ADDR_W-1:0]      start_addr_i,
   input  logic [AMM_BURST_W-1:0] burst_cnt_i,
   input  logic [CNT_W-1:0]       trans_cnt_i,
   output logic                   cmd_valid_o,
   input  logic                   cmd_ready_i,
   output logic                   cmd_write_o,
   output logic [ADDR_W-1:0]      cmd_addr_o,
   output logic [AMM_BURST_W-1:0] cmd_burst_o,
   output logic                   busy_o,
   output logic                   done_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam logic [1:0] MODE_RD  = 2'd1;
   localparam logic [1:0] MODE_WR  = 2'd2;
   localparam logic [1:0] MODE_WAC = 2'd3;

   state_t                 state, state_nxt;
   logic [1:0]             mode_q;
   logic [2:0]             amode_q;
   logic [ADDR_W-1:0]      base_q, inc_q, run_q, addr_sel;
   logic [AMM_BURST_W-1:0] burst_q;
   logic [CNT_W-1:0]       cnt_q, n_q;
   logic                   phase_q, stop_q;
   logic                   start_ok, accept, pair_end, last_n;

   assign start_ok = start_i && (state == IDLE);
   assign accept   = cmd_valid_o && cmd_ready_i;
   // phase_q=1 marks the read half of a write-and-check pair
   assign pair_end = accept && ((mode_q != MODE_WAC) || phase_q);
   assign last_n   = (n_q == cnt_q - CNT_W'(1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_ok)
                  state_nxt = (test_mode_i == 2'd0 || trans_cnt_i == '0) ? DONE : ISSUE;
         ISSUE: if (pair_end && (last_n || stop_q || stop_i)) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef TRANS_SCHED_RND_ADDR_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)      lfsr_q <= 16'hACE1;
      else if (start_ok) lfsr_q <= 16'hACE1;
      else if (pair_end) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
`endif

   // inc_q tracks start + n*burst and run_q tracks 1 << (n mod ADDR_W) incrementally
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mode_q  <= '0;
         amode_q <= '0;
         base_q  <= '0;
         inc_q   <= '0;
         run_q   <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         phase_q <= 1'b0;
         stop_q  <= 1'b0;
      end else if (start_ok) begin
         mode_q  <= test_mode_i;
         amode_q <= addr_mode_i;
         base_q  <= start_addr_i;
         inc_q   <= start_addr_i;
         run_q   <= ADDR_W'(1);
         burst_q <= (burst_cnt_i == '0) ? AMM_BURST_W'(1) : burst_cnt_i;
         cnt_q   <= trans_cnt_i;
         n_q     <= '0;
         phase_q <= 1'b0;
         stop_q  <= 1'b0;
      end else if (state == ISSUE) begin
         if (stop_i) stop_q <= 1'b1;
         if (pair_end) begin
            phase_q <= 1'b0;
            n_q     <= n_q + CNT_W'(1);
            inc_q   <= inc_q + ADDR_W'(burst_q);
            run_q   <= {run_q[ADDR_W-2:0], run_q[ADDR_W-1]};
         end else if (accept) begin
            phase_q <= 1'b1;
         end
      end
   end

   always_comb begin
      addr_sel = base_q;
      case (amode_q)
`ifdef TRANS_SCHED_RND_ADDR_EN
         3'd1: addr_sel = lfsr_q[ADDR_W-1:0];
`else
         3'd1: addr_sel = inc_q;
`endif
         3'd2: addr_sel = ~run_q;
         3'd3: addr_sel = run_q;
         3'd4: addr_sel = inc_q;
         default: addr_sel = base_q;
      endcase
   end

   assign cmd_valid_o = (state == ISSUE);
   assign cmd_write_o = cmd_valid_o && ((mode_q == MODE_WR) || (mode_q == MODE_WAC && !phase_q));
   assign cmd_addr_o  = cmd_valid_o ? addr_sel : '0;
   assign cmd_burst_o = cmd_valid_o ? burst_q : '0;
   assign busy_o      = (state != IDLE);
   assign done_o      = (state == DONE);

   logic unused_mode;
   assign unused_mode = (mode_q == MODE_RD);

endmodule

// File: tb/tb_trans_scheduler.sv
// Directed bench for trans_scheduler: address modes, handshake stalls, stop, zero count and reset.
module tb_trans_scheduler;
   localparam int ADDR_W = 6;
   localparam int BW     = 11;
   localparam int CW     = 32;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          start_i = 1'b0, stop_i = 1'b0, cmd_ready_i = 1'b1;
   logic [1:0]    test_mode_i = '0;
   logic [2:0]    addr_mode_i = '0;
   logic [ADDR_W-1:0] start_addr_i = '0;
   logic [BW-1:0] burst_cnt_i = '0;
   logic [CW-1:0] trans_cnt_i = '0;
   logic          cmd_valid_o, cmd_write_o, busy_o, done_o;
   logic [ADDR_W-1:0] cmd_addr_o;
   logic [BW-1:0] cmd_burst_o;

   int checks = 0;
   int errors = 0;

   trans_scheduler #(.ADDR_W(ADDR_W), .AMM_BURST_W(BW), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stop_i(stop_i),
      .test_mode_i(test_mode_i), .addr_mode_i(addr_mode_i), .start_addr_i(start_addr_i),
      .burst_cnt_i(burst_cnt_i), .trans_cnt_i(trans_cnt_i), .cmd_valid_o(cmd_valid_o),
      .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o), .cmd_addr_o(cmd_addr_o),
      .cmd_burst_o(cmd_burst_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_seq(input logic [1:0] m, input logic [2:0] am, input logic [ADDR_W-1:0] a,
                            input logic [BW-1:0] b, input logic [CW-1:0] c);
      test_mode_i = m; addr_mode_i = am; start_addr_i = a; burst_cnt_i = b; trans_cnt_i = c;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   logic [ADDR_W-1:0] run0_exp [7];
   logic [ADDR_W-1:0] rnd1 [4];
   int k, ncmd;

   initial begin
      run0_exp = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
      #12;
      chk("rst_valid", cmd_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_addr", cmd_addr_o, 0);
      rst_n_i = 1'b1;
      tick();

      // WRITE_ONLY INC_ADDR with wrap: 60, 0, 4
      start_seq(2'd2, 3'd4, 6'd60, 11'd4, 32'd3);
      start_addr_i = 6'd9; burst_cnt_i = 11'd7; test_mode_i = 2'd1;
      chk("t1_busy", busy_o, 1);
      chk("t1_valid0", cmd_valid_o, 1);
      chk("t1_write0", cmd_write_o, 1);
      chk("t1_burst0", cmd_burst_o, 4);
      chk("t1_addr0", cmd_addr_o, 60);
      tick();
      chk("t1_addr1", cmd_addr_o, 0);
      chk("t1_valid1", cmd_valid_o, 1);
      tick();
      chk("t1_addr2", cmd_addr_o, 4);
      tick();
      chk("t1_done", done_o, 1);
      chk("t1_valid_off", cmd_valid_o, 0);
      chk("t1_busy_done", busy_o, 1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("t1_busy_off", busy_o, 0);
      chk("t1_done_off", done_o, 0);
      tick();
      chk("t1_start_in_done_ignored", busy_o, 0);

      // WRITE_AND_CHECK FIX 5, ready toggling
      start_seq(2'd3, 3'd0, 6'd5, 11'd2, 32'd2);
      k = 0;
      for (int i = 0; i < 20 && k < 4; i++) begin
         cmd_ready_i = (i % 2 == 0);
         chk("t2_valid", cmd_valid_o, 1);
         chk("t2_write", cmd_write_o, (k % 2 == 0));
         chk("t2_addr", cmd_addr_o, 5);
         chk("t2_burst", cmd_burst_o, 2);
         if (cmd_ready_i) k++;
         tick();
      end
      cmd_ready_i = 1'b1;
      chk("t2_accepts", k, 4);
      chk("t2_done", done_o, 1);
      chk("t2_valid_off", cmd_valid_o, 0);
      tick();
      chk("t2_done_once", done_o, 0);

      // READ_ONLY RUN_0, burst 0 treated as 1
      start_seq(2'd1, 3'd2, 6'd0, 11'd0, 32'd7);
      for (int i = 0; i < 7; i++) begin
         chk("t3_addr", cmd_addr_o, run0_exp[i]);
         chk("t3_write", cmd_write_o, 0);
         chk("t3_burst", cmd_burst_o, 1);
         tick();
      end
      chk("t3_done", done_o, 1);
      tick();

      // zero count, then invalid mode
      start_seq(2'd2, 3'd0, 6'd3, 11'd1, 32'd0);
      chk("t4_zero_done", done_o, 1);
      chk("t4_zero_valid", cmd_valid_o, 0);
      tick();
      chk("t4_zero_idle", busy_o, 0);
      start_seq(2'd0, 3'd0, 6'd3, 11'd1, 32'd5);
      chk("t4_mode_done", done_o, 1);
      chk("t4_mode_valid", cmd_valid_o, 0);
      tick();
      chk("t4_mode_idle", busy_o, 0);

      // stop raised while the third write is presented
      stop_i = 1'b1;
      tick();
      chk("t5_stop_idle", busy_o, 0);
      stop_i = 1'b0;
      start_seq(2'd3, 3'd0, 6'd7, 11'd1, 32'd10);
      ncmd = 0;
      for (int i = 0; i < 40 && !done_o; i++) begin
         if (ncmd == 4) begin
            chk("t5_stop_on_write", cmd_write_o, 1);
            stop_i = 1'b1;
         end
         if (cmd_valid_o && cmd_ready_i) ncmd++;
         tick();
      end
      stop_i = 1'b0;
      chk("t5_done", done_o, 1);
      chk("t5_cmds", ncmd, 6);
      tick();

      // RND_ADDR twice from the same seed
      start_seq(2'd1, 3'd1, 6'h10, 11'd1, 32'd4);
      for (int i = 0; i < 4; i++) begin
         rnd1[i] = cmd_addr_o;
`ifndef TRANS_SCHED_RND_ADDR_EN
         chk("t6_rnd_as_inc", cmd_addr_o, 6'h10 + i);
`endif
         tick();
      end
`ifdef TRANS_SCHED_RND_ADDR_EN
      chk("t6_seed_addr", rnd1[0], 6'h21);
`endif
      tick();
      start_seq(2'd1, 3'd1, 6'h10, 11'd1, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t6_repeat", cmd_addr_o, rnd1[i]);
         tick();
      end
      chk("t6_done", done_o, 1);
      tick();

      // async reset mid-sequence
      start_seq(2'd2, 3'd4, 6'd1, 11'd1, 32'd10);
      tick();
      #2 rst_n_i = 1'b0;
      #1;
      chk("t7_rst_valid", cmd_valid_o, 0);
      chk("t7_rst_busy", busy_o, 0);
      chk("t7_rst_write", cmd_write_o, 0);
      chk("t7_rst_addr", cmd_addr_o, 0);
      rst_n_i = 1'b1;
      tick();
      chk("t7_after_idle", busy_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/trans_scheduler.md
# trans_scheduler

Sequences the Avalon-MM test traffic of the memory checker. On a start pulse it latches the test settings (test mode, address mode, start word address, burst length, transaction count) and emits a stream of burst commands to the downstream write/read engines over a valid/ready handshake. It asserts done when the last command has been accepted. It sits between the CSR block and the AMM master datapath.

## Interface
- `ADDR_W`, 6: word address width; legal range 2..16.
- `AMM_BURST_W`, 11: burst count width.
- `CNT_W`, 32: transaction counter width.
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `start_i`  in  1  one-cycle start pulse; ignored while `busy_o`=1.
- `stop_i`  in  1  level; requests a graceful stop.
- `test_mode_i`  in  2  0=invalid, 1=READ_ONLY, 2=WRITE_ONLY, 3=WRITE_AND_CHECK.
- `addr_mode_i`  in  3  0=FIX_ADDR, 1=RND_ADDR, 2=RUN_0, 3=RUN_1, 4=INC_ADDR; 5..7 behave as FIX_ADDR.
- `start_addr_i`  in  ADDR_W  base word address.
- `burst_cnt_i`  in  AMM_BURST_W  words per command; 0 is treated as 1.
- `trans_cnt_i`  in  CNT_W  number of transactions (a write+read pair counts as one).
- `cmd_valid_o`  out  1  command valid.
- `cmd_ready_i`  in  1  downstream accepts the command.
- `cmd_write_o`  out  1  1=write, 0=read.
- `cmd_addr_o`  out  ADDR_W  command word address.
- `cmd_burst_o`  out  AMM_BURST_W  command burst count.
- `busy_o`  out  1  a sequence is in progress.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- All settings are latched on an accepted `start_i`. Later input changes have no effect until the next start.
- States:
  - IDLE: accepted start → ISSUE. If `test_mode_i`=0 or `trans_cnt_i`=0, go to DONE instead.
  - ISSUE: present the command. On `cmd_ready_i`, advance the sequence.
  - DONE: pulse `done_o` for one cycle, then return to IDLE.
- Transaction index n runs 0..trans_cnt-1.
- READ_ONLY issues one read per n. WRITE_ONLY issues one write per n.
- WRITE_AND_CHECK issues a write, then a read, per n. Both commands carry the same address and burst. n increments after the read is accepted.
- Address generation per n:
  - FIX_ADDR: start_addr.
  - INC_ADDR: (start_addr + n·burst) mod 2^ADDR_W. The wrap is silent.
  - RUN_1: 1 << (n mod ADDR_W).
  - RUN_0: ~(1 << (n mod ADDR_W)).
  - RND_ADDR: lfsr[ADDR_W-1:0].
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, reloaded with 16'hACE1 at each start. It steps when n increments.
- After the final command for n = trans_cnt-1 is accepted, go to DONE.
- `stop_i` sampled high in ISSUE:
  - The currently presented command completes normally; it is never withdrawn.
  - In WRITE_AND_CHECK, a pending read of the current pair is still issued.
  - Then go to DONE.
- `stop_i` in IDLE has no effect.

## Timing
- Reset value of every output is 0. State resets to IDLE, counters to 0, LFSR to 16'hACE1.
- Start accepted at cycle T: `busy_o`=1 and `cmd_valid_o`=1 from T+1.
- Command fields are stable while `cmd_valid_o`=1 and `cmd_ready_i`=0.
- With `cmd_ready_i` held high, one command is accepted per cycle with no bubbles.
- Final acceptance at cycle A: `cmd_valid_o`=0 and `done_o`=1 at A+1; `busy_o`=0 at A+2.
- Start with zero count or invalid mode at cycle T: `done_o`=1 at T+1, no commands issued.
- A `start_i` that coincides with the `done_o` cycle is ignored.
- Reset asserted mid-sequence: all outputs drop to 0 asynchronously. Any in-flight command is abandoned.
- Counter arithmetic is CNT_W-bit unsigned. Address arithmetic is ADDR_W-bit with modulo wrap.

## Configuration
- `TRANS_SCHED_RND_ADDR_EN` defined: the LFSR is present and RND_ADDR works as specified.
- Undefined: no LFSR is built, and RND_ADDR behaves exactly as INC_ADDR.

## Test plan
- ADDR_W=6, WRITE_ONLY, INC_ADDR, start 60, burst 4, count 3, ready always high → writes to 60, 0, 4 on three consecutive cycles; `done_o` one cycle later.
- WRITE_AND_CHECK, FIX_ADDR 5, burst 2, count 2, ready toggling 1/0 → W5, R5, W5, R5. Fields hold while ready is low. Exactly 4 acceptances, then one done pulse.
- READ_ONLY, RUN_0, ADDR_W=6, count 7 → addresses 0x3E, 0x3D, 0x3B, 0x37, 0x2F, 0x1F, 0x3E.
- `trans_cnt_i`=0, and separately `test_mode_i`=0 → no `cmd_valid_o`; `done_o` at T+1.
- WRITE_AND_CHECK, count 10, `stop_i` raised while a write is presented → that write and its read are accepted, then done. Total commands is even and less than 20.
- RND_ADDR, count 4, run twice → identical address sequences on both runs (seed 16'hACE1); with the macro undefined, the addresses match INC_ADDR.
